bsg_rr_tag_demux_fifo: RTL and testbench

// - Downstream companion to the round-robin n-to-1 arbiter. Consumes its v/data/tag stream on a

---
 rtl/bsg_rr_tag_demux_fifo_if.sv | 26 ++
 rtl/bsg_rr_tag_demux_fifo.sv | 115 +++++++++++
 tb/tb_bsg_rr_tag_demux_fifo.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/bsg_rr_tag_demux_fifo_if.sv
// Handshake bundle for bsg_rr_tag_demux_fifo: upstream valid/yumi entry stream plus
// per-port valid/ready destination side. The DUT uses the slave modport.
interface bsg_rr_tag_demux_fifo_if #(
  parameter int width_p   = 16,
  parameter int num_out_p = 2
);
  localparam int tag_width_lp = (num_out_p > 1) ? $clog2(num_out_p) : 1;

  logic                    v;
  logic [width_p-1:0]      data;
  logic [tag_width_lp-1:0] tag;
  logic                    yumi;
  logic [num_out_p-1:0]    out_v;
  logic [width_p-1:0]      out_data;
  logic [num_out_p-1:0]    ready;

  modport master (
    output v, data, tag, ready,
    input  yumi, out_v, out_data
  );

  modport slave (
    input  v, data, tag, ready,
    output yumi, out_v, out_data
  );
endinterface

// File: rtl/bsg_rr_tag_demux_fifo.sv
// Tag-steered FIFO behind a round-robin arbiter: buffers els_p entries and presents the head
// to port head.tag. Define BSG_RR_TAG_DEMUX_BYPASS_EN for zero-latency pass-through when empty.
module bsg_rr_tag_demux_fifo #(
  parameter int width_p   = 16,
  parameter int num_out_p = 2,
  parameter int els_p     = 4,
  localparam int tag_width_lp   = (num_out_p > 1) ? $clog2(num_out_p) : 1,
  localparam int count_width_lp = $clog2(els_p + 1),
  localparam int ptr_width_lp   = $clog2(els_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  bsg_rr_tag_demux_fifo_if.slave    io,
  output logic [count_width_lp-1:0] count_o,
  output logic                      err_o
);

  logic [width_p-1:0]      data_mem [els_p];
  logic [tag_width_lp-1:0] tag_mem  [els_p];
  logic [ptr_width_lp-1:0] rd_ptr, wr_ptr;
  logic [count_width_lp-1:0] count;
  logic                    err;

  logic                    empty, full;
  logic [tag_width_lp-1:0] head_tag;
  logic                    head_ok;
  logic [num_out_p-1:0]    head_hot;
  logic                    enq_ok, wr, deq, byp;

  function automatic logic [ptr_width_lp-1:0] ptr_next(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == count_width_lp'(els_p));
  assign head_tag = tag_mem[rd_ptr];
  assign head_ok  = (32'(head_tag) < num_out_p);

  always_comb begin
    head_hot = '0;
    if (head_ok) head_hot[head_tag] = 1'b1;
  end

  // Out-of-range heads are dequeued unconditionally so they never stall the queue.
  assign deq    = ~empty & ~reset_i & (~head_ok | (|(head_hot & io.ready)));
  assign enq_ok = io.v & ~full & ~reset_i;

`ifdef BSG_RR_TAG_DEMUX_BYPASS_EN
  logic                 in_ok;
  logic [num_out_p-1:0] in_hot;

  assign in_ok = (32'(io.tag) < num_out_p);

  always_comb begin
    in_hot = '0;
    if (in_ok) in_hot[io.tag] = 1'b1;
  end

  assign byp = empty & io.v & ~reset_i & (|(in_hot & io.ready));

  always_comb begin
    io.out_v    = '0;
    io.out_data = data_mem[rd_ptr];
    if (byp) begin
      io.out_v    = in_hot;
      io.out_data = io.data;
    end else if (~empty & ~reset_i) begin
      io.out_v = head_hot;
    end
  end
`else
  assign byp = 1'b0;

  always_comb begin
    io.out_v    = '0;
    io.out_data = data_mem[rd_ptr];
    if (~empty & ~reset_i) io.out_v = head_hot;
  end
`endif

  assign io.yumi = enq_ok | byp;
  assign wr      = enq_ok & ~byp;
  assign count_o = count;
  assign err_o   = err;

  always_ff @(posedge clk_i) begin
    if (wr) begin
      data_mem[wr_ptr] <= io.data;
      tag_mem[wr_ptr]  <= io.tag;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= ptr_next(wr_ptr);
      if (deq) rd_ptr <= ptr_next(rd_ptr);
      count <= count + count_width_lp'(wr) - count_width_lp'(deq);
      if (~empty & ~head_ok) err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert ($onehot0(io.out_v));
      assert (32'(count) <= els_p);
      assert (!(deq && empty));
    end
  end

endmodule

// File: tb/tb_bsg_rr_tag_demux_fifo.sv
// Scoreboard bench for bsg_rr_tag_demux_fifo (num_out_p=3, els_p=4): the monitor models the
// FIFO as a queue of {tag,data} and checks handshakes, data, count and sticky error each cycle.
module tb_bsg_rr_tag_demux_fifo;
  localparam int W = 16;
  localparam int N = 3;
  localparam int E = 4;

  typedef struct {
    logic [1:0]   tag;
    logic [W-1:0] data;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] count;
  logic       err;

  bsg_rr_tag_demux_fifo_if #(.width_p(W), .num_out_p(N)) bus ();

  bsg_rr_tag_demux_fifo #(.width_p(W), .num_out_p(N), .els_p(E)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .io      (bus.slave),
    .count_o (count),
    .err_o   (err)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  ent_t sb[$];
  ent_t st_q[$];
  bit   m_err = 0;
  bit   acc   = 0;
  int   vmode = 0;
  bit   rdy_rand = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference monitor: decisions come from the queue model, never from DUT outputs.
  always @(negedge clk) begin
    ent_t       h;
    logic [2:0] exp_v;
    bit         exp_yumi, deq, byp, head_bad;
    acc = bus.yumi;
    if (rst) begin
      check("yumi_in_reset", int'(bus.yumi), 0);
      sb.delete();
      m_err = 0;
    end else begin
      check("count", int'(count), sb.size());
      check("err", int'(err), int'(m_err));
      exp_v = '0; deq = 0; byp = 0; head_bad = 0;
      if (sb.size() > 0) begin
        h = sb[0];
        if (h.tag < 2'(N)) begin
          exp_v = 3'(1) << h.tag;
          deq   = bus.ready[h.tag];
        end else begin
          deq = 1; head_bad = 1;
        end
      end
`ifdef BSG_RR_TAG_DEMUX_BYPASS_EN
      else if (bus.v && bus.tag < 2'(N) && bus.ready[bus.tag]) begin
        byp   = 1;
        exp_v = 3'(1) << bus.tag;
      end
`endif
      exp_yumi = byp || (bus.v && sb.size() < E);
      check("v_o", int'(bus.out_v), int'(exp_v));
      if (exp_v != 0) check("data_o", int'(bus.out_data), byp ? int'(bus.data) : int'(h.data));
      check("yumi", int'(bus.yumi), int'(exp_yumi));
      if (deq) void'(sb.pop_front());
      if (exp_yumi && !byp) sb.push_back('{tag: bus.tag, data: bus.data});
      if (head_bad) m_err = 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (!bus.v || acc) begin
        if (st_q.size() > 0) begin
          ent_t e;
          e = st_q.pop_front();
          bus.v = 1'b1; bus.tag = e.tag; bus.data = e.data;
        end else if (vmode == 1) begin
          bus.v = 1'b1; bus.tag = 2'($urandom_range(0, N - 1)); bus.data = W'($urandom);
        end else if (vmode == 2) begin
          bus.v    = ($urandom_range(0, 3) != 0);
          bus.tag  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, N - 1));
          bus.data = W'($urandom);
        end else begin
          bus.v = 1'b0;
        end
      end
      if (rdy_rand) bus.ready = 3'($urandom);
    end
  endtask

  task automatic push(input logic [1:0] t, input logic [W-1:0] d);
    st_q.push_back('{tag: t, data: d});
  endtask

  initial begin
    bus.v = 1'b0; bus.tag = '0; bus.data = '0; bus.ready = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step(10);

    bus.ready = 3'b111;
    push(2'd0, 16'hAAAA); push(2'd1, 16'h5555);
    step(6);

    bus.ready = 3'b000;
    for (int i = 0; i < 5; i++) push(2'(i % N), W'(16'h1000 + i));
    step(8);
    bus.ready = 3'b111;
    step(8);

    bus.ready = 3'b001;
    push(2'd1, 16'h1111); push(2'd0, 16'h2222);
    step(5);
    bus.ready = 3'b010;
    step(3);
    bus.ready = 3'b111;
    step(3);

    push(2'd3, 16'h0BAD); push(2'd2, 16'h2BAD);
    step(5);

    bus.ready = 3'b000;
    for (int i = 0; i < 5; i++) push(2'(i % N), W'(16'h3000 + i));
    step(7);
    bus.ready = 3'b111;
    vmode = 1;
    step(10);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    step(10);

    vmode = 2; rdy_rand = 1;
    step(400);

    vmode = 0; rdy_rand = 0; bus.ready = 3'b111;
    step(12);
    @(negedge clk);
    check("drained", sb.size(), 0);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
